lut_sweep_engine: RTL and testbench
===================================

// Module: lut_sweep_engine
// PURPOSE
//  Programmable N_IN-input, N_OUT-output truth-table evaluator with a built-in sweep sequencer.
//  On start it walks an index range over the input space and streams one result beat per index
//  over a valid/ready handshake. At sweep end it reports a per-output ones count.
//  Sequential successor to the fixed 4-input f4/f5/f6 breadboard logic; the default table reproduces it.
// PARAMETERS
//  N_IN     4                        input variables; DEPTH = 2**N_IN table rows
//  N_OUT    3                        output functions
//  LUT_INIT 48'h212E_111F_8888       reset tables {f(N_OUT-1),...,f0}, DEPTH bits each, bit i = f(i)
//                                    (defaults: f0=yz, f1=y'z'+w'x', f2=f6 SOP; index={w,x,y,z}, z=LSB)
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              async active-low reset
//  cfg_we     in   1              write one function table
//  cfg_sel    in   clog2(N_OUT)   function index to write
//  cfg_data   in   DEPTH          new truth table
//  start      in   1              begin sweep (pulse)
//  range_lo   in   N_IN           first index, sampled on accepted start
//  range_hi   in   N_IN           last index, sampled on accepted start
//  busy       out  1              sweep in progress
//  out_valid  out  1              result beat valid
//  out_ready  in   1              sink accepts beat
//  out_idx    out  N_IN           input vector of this beat
//  out_f      out  N_OUT          function values at out_idx
//  out_last   out  1              final beat of sweep
//  done       out  1              one-cycle pulse after final handshake
//  ones_cnt   out  N_OUT*(N_IN+1) per-function count of 1s over swept beats
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; busy, out_valid, out_last and done = 0; out_idx, out_f and
//   ones_cnt = 0; tables reload LUT_INIT. A reset mid-sweep aborts with no done pulse.
//  FSM: IDLE -> RUN on start; RUN -> DONE on handshake while out_last; DONE -> IDLE next cycle
//   (done=1 only in DONE).
//  Start accepted only in IDLE: latch lo/hi, clear ones_cnt, busy=1 the next cycle. Start in
//   RUN/DONE is ignored.
//  Latency: first beat (out_idx=lo) has out_valid=1 one cycle after start is accepted.
//  Handshake: a beat transfers when out_valid & out_ready. While out_valid=1 and out_ready=0,
//   out_idx/out_f/out_last hold stable. On transfer the next beat appears the following cycle, so
//   out_ready held high gives one beat per clock with no bubbles.
//  Index advance is idx+1 mod DEPTH. lo>hi wraps through DEPTH-1 to 0. lo==hi gives one beat.
//   lo=0, hi=DEPTH-1 gives a full sweep. Beat count = ((hi-lo) mod DEPTH)+1.
//  out_last=1 exactly when out_idx==hi and the beat is valid.
//  ones_cnt[k] increments by out_f[k] on each transfer. Width N_IN+1, so there is no overflow at
//   DEPTH ones. The value is held after DONE until the next accepted start.
//  out_f is a registered table read at out_idx: out_f[k] = table[k][out_idx].
//  Config writes are accepted only in IDLE (incl. the start cycle). They are ignored while busy or
//   in DONE. cfg_sel >= N_OUT is ignored.
//  cfg_we and start in the same IDLE cycle: the write lands first, so the sweep uses the new table.
//  busy=1 in RUN and DONE.
// STRUCTURE
//  SV package lut_sweep_pkg:
//   - state enum {IDLE, RUN, DONE}
//   - DEPTH/width localparam functions
//   - default LUT_INIT constant
//  Sub-module lut_bank: N_OUT x DEPTH table storage, write port and registered read.
//  Top module: FSM, index counter, handshake output register and popcount accumulators.
// TESTING
//  1 Defaults, lo=0 hi=15, ready=1: 16 back-to-back beats match the f4/f5/f6 truth table;
//    out_last at idx15; ones_cnt={6,7,4}; done pulses once.
//  2 lo=14 hi=1: beats idx 14,15,0,1 with out_last on 1. lo=hi=5: one beat, f={1,0,0},
//    out_last=1.
//  3 out_ready random 50% during a full sweep: no beat dropped or duplicated; data stable
//    across stalls; counts unchanged vs scenario 1.
//  4 Write cfg_sel=0 cfg_data=16'hFFFF together with start: every beat has f0=1 and
//    ones_cnt[0]=16. A cfg write mid-sweep has no effect.
//  5 Start while busy is ignored. rst_n low mid-sweep: out_valid=0, no done, table back to
//    LUT_INIT, and a fresh start then sweeps correctly.

Source files
------------

// File: rtl/lut_sweep_engine_pkg.sv
// Shared types and sizing helpers for the LUT sweep engine.
// The default table reproduces the 4-input f4/f5/f6 breadboard functions.
package lut_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_N_IN  = 4;
    localparam int DEF_N_OUT = 3;

    // {f2, f1, f0}; bit i of each table is f(i), index = {w,x,y,z}
    localparam logic [47:0] DEF_LUT_INIT = 48'h212E_111F_8888;

    function automatic int lut_depth(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic int sel_width(input int n_out);
        return (n_out > 1) ? $clog2(n_out) : 1;
    endfunction

    function automatic int cnt_width(input int n_in);
        return n_in + 1;
    endfunction

endpackage

// File: rtl/lut_sweep_engine_if.sv
// Config, sweep-control and result-stream signals of the LUT sweep engine.
// master drives config/start/ready; slave (the engine) drives the result beat and status.
interface lut_sweep_engine_if
    import lut_sweep_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int N_OUT = DEF_N_OUT
);
    localparam int DEPTH = lut_depth(N_IN);
    localparam int SEL_W = sel_width(N_OUT);
    localparam int CNT_W = cnt_width(N_IN);

    logic                     cfg_we;
    logic [SEL_W-1:0]         cfg_sel;
    logic [DEPTH-1:0]         cfg_data;
    logic                     start;
    logic [N_IN-1:0]          range_lo;
    logic [N_IN-1:0]          range_hi;
    logic                     busy;
    logic                     out_valid;
    logic                     out_ready;
    logic [N_IN-1:0]          out_idx;
    logic [N_OUT-1:0]         out_f;
    logic                     out_last;
    logic                     done;
    logic [N_OUT*CNT_W-1:0]   ones_cnt;

    modport master (
        output cfg_we, cfg_sel, cfg_data, start, range_lo, range_hi, out_ready,
        input  busy, out_valid, out_idx, out_f, out_last, done, ones_cnt
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_data, start, range_lo, range_hi, out_ready,
        output busy, out_valid, out_idx, out_f, out_last, done, ones_cnt
    );

endinterface

// File: rtl/lut_sweep_engine_lut_bank.sv
// N_OUT truth tables with one write port and a registered read of all functions at one index.
// Read data lands one cycle after the address; a same-cycle write to a table is forwarded.
module lut_bank
    import lut_sweep_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int N_OUT = DEF_N_OUT,
    parameter logic [N_OUT*lut_depth(N_IN)-1:0] LUT_INIT = DEF_LUT_INIT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_we,
    input  logic [sel_width(N_OUT)-1:0]  i_sel,
    input  logic [lut_depth(N_IN)-1:0]   i_wdata,
    input  logic [N_IN-1:0]              i_raddr,
    output logic [N_OUT-1:0]             o_rdata
);
    localparam int DEPTH = lut_depth(N_IN);
    localparam int SEL_W = sel_width(N_OUT);

    logic [DEPTH-1:0] r_tbl [N_OUT];
    logic [N_OUT-1:0] r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_OUT; k++) begin
                r_tbl[k] <= LUT_INIT[k*DEPTH +: DEPTH];
            end
            r_rdata <= '0;
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (i_we && (i_sel == SEL_W'(k))) begin
                    r_tbl[k]   <= i_wdata;
                    r_rdata[k] <= i_wdata[i_raddr];
                end else begin
                    r_rdata[k] <= r_tbl[k][i_raddr];
                end
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/lut_sweep_engine.sv
// Sweeps an index range through the LUT bank, streaming one beat per index; first beat 1 cycle after start.
// Beats hold while out_ready is low; with out_ready high the stream runs one beat per clock.
module lut_sweep_engine
    import lut_sweep_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int N_OUT = DEF_N_OUT,
    parameter logic [N_OUT*lut_depth(N_IN)-1:0] LUT_INIT = DEF_LUT_INIT
) (
    input  logic               clk,
    input  logic               rst_n,
    lut_sweep_engine_if.slave  bus
);
    localparam int CNT_W = cnt_width(N_IN);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [N_IN-1:0]        r_idx;
    logic [N_IN-1:0]        r_hi;
    logic [CNT_W-1:0]       r_cnt [N_OUT];

    logic                   w_start_acc;
    logic                   w_cfg_we;
    logic                   w_valid;
    logic                   w_last;
    logic                   w_xfer;
    logic [N_IN-1:0]        w_idx_inc;
    logic [N_IN-1:0]        w_raddr;
    logic [N_OUT-1:0]       w_f;
    logic [N_OUT*CNT_W-1:0] w_ones;

    assign w_start_acc = bus.start && (r_state == IDLE);
    assign w_cfg_we    = bus.cfg_we && (r_state == IDLE) && (32'(bus.cfg_sel) < N_OUT);
    assign w_valid     = (r_state == RUN);
    assign w_last      = w_valid && (r_idx == r_hi);
    assign w_xfer      = w_valid && bus.out_ready;
    assign w_idx_inc   = r_idx + N_IN'(1);

    // Address the bank with the index that will be presented next cycle so out_f tracks out_idx.
    assign w_raddr = w_start_acc            ? bus.range_lo :
                     (w_xfer && !w_last)    ? w_idx_inc    :
                                              r_idx;

    lut_bank #(
        .N_IN     (N_IN),
        .N_OUT    (N_OUT),
        .LUT_INIT (LUT_INIT)
    ) u_lut_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (w_cfg_we),
        .i_sel    (bus.cfg_sel),
        .i_wdata  (bus.cfg_data),
        .i_raddr  (w_raddr),
        .o_rdata  (w_f)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = RUN;
            RUN:     if (w_xfer && w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_hi    <= '0;
            for (int k = 0; k < N_OUT; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_start_acc) begin
                r_idx <= bus.range_lo;
                r_hi  <= bus.range_hi;
                for (int k = 0; k < N_OUT; k++) begin
                    r_cnt[k] <= '0;
                end
            end else if (w_xfer) begin
                for (int k = 0; k < N_OUT; k++) begin
                    r_cnt[k] <= r_cnt[k] + CNT_W'(w_f[k]);
                end
                if (!w_last) begin
                    r_idx <= w_idx_inc;
                end
            end
        end
    end

    always_comb begin
        w_ones = '0;
        for (int k = 0; k < N_OUT; k++) begin
            w_ones[k*CNT_W +: CNT_W] = r_cnt[k];
        end
    end

    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = (r_state == DONE);
    assign bus.out_valid = w_valid;
    assign bus.out_last  = w_last;
    assign bus.out_idx   = r_idx;
    assign bus.out_f     = w_f;
    assign bus.ones_cnt  = w_ones;

endmodule

// File: tb/tb_lut_sweep_engine.sv
// Bench for lut_sweep_engine: table of sweep vectors, hand-written corner sequences and random sweeps,
// every beat compared against a truth-table model held in arrays.
module tb_lut_sweep_engine;

    logic clk;
    logic rst_n;

    lut_sweep_engine_if #(.N_IN(4), .N_OUT(3)) bus ();

    lut_sweep_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;

    logic [15:0] ref_tbl [3];

    typedef struct {
        logic [3:0]  lo;
        logic [3:0]  hi;
        bit          rnd;
        bit          cfg;
        logic [1:0]  sel;
        logic [15:0] data;
        int          beats;
        logic [14:0] cnt;
    } vec_t;

    vec_t vec [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [14:0] pk(input int c2, input int c1, input int c0);
        return {5'(c2), 5'(c1), 5'(c0)};
    endfunction

    function automatic logic [2:0] mf(input logic [3:0] i);
        logic [2:0] r;
        for (int k = 0; k < 3; k++) begin
            r[k] = ref_tbl[k][i];
        end
        return r;
    endfunction

    task automatic model_defaults();
        ref_tbl[0] = 16'h8888;
        ref_tbl[1] = 16'h111F;
        ref_tbl[2] = 16'h212E;
    endtask

    task automatic do_sweep(input logic [3:0] lo, input logic [3:0] hi, input bit rnd,
                            input bit cfg, input logic [1:0] sel, input logic [15:0] data,
                            input bit disturb, output int beats, output logic [14:0] cnt_out);
        logic [3:0]  span;
        logic [3:0]  eidx;
        int          nb;
        int          n;
        int          cyc;
        int          hs;
        int          mcnt [3];
        bit          rdy;

        @(negedge clk);
        bus.start    = 1'b1;
        bus.range_lo = lo;
        bus.range_hi = hi;
        bus.cfg_we   = cfg;
        bus.cfg_sel  = sel;
        bus.cfg_data = data;
        if (cfg && sel < 2'd3) ref_tbl[sel] = data;

        span = hi - lo;
        nb   = int'(span) + 1;
        for (int k = 0; k < 3; k++) mcnt[k] = 0;
        for (int i = 0; i < nb; i++) begin
            eidx = lo + 4'(i);
            for (int k = 0; k < 3; k++) mcnt[k] += int'(ref_tbl[k][eidx]);
        end

        n   = 0;
        cyc = 0;
        hs  = 0;
        while (n < nb && cyc < 400) begin
            @(negedge clk);
            cyc++;
            bus.start  = 1'b0;
            bus.cfg_we = 1'b0;
            if (disturb && cyc == 3) begin
                bus.start    = 1'b1;
                bus.range_lo = lo + 4'd7;
                bus.range_hi = lo;
                bus.cfg_we   = 1'b1;
                bus.cfg_sel  = 2'd1;
                bus.cfg_data = 16'h0000;
            end
            rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            bus.out_ready = rdy;
            eidx = lo + 4'(n);
            chk("out_valid", 64'(bus.out_valid), 64'd1);
            chk("out_idx",   64'(bus.out_idx),   64'(eidx));
            chk("out_f",     64'(bus.out_f),     64'(mf(eidx)));
            chk("out_last",  64'(bus.out_last),  64'(n == nb - 1));
            if (bus.out_valid && rdy) hs++;
            if (rdy) n++;
        end
        if (n < nb) chk("sweep_timeout", 64'(n), 64'(nb));
        if (!rnd) chk("no_bubbles", 64'(cyc), 64'(nb));

        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("done_pulse",  64'(bus.done),      64'd1);
        chk("valid_after", 64'(bus.out_valid), 64'd0);
        chk("busy_done",   64'(bus.busy),      64'd1);
        @(negedge clk);
        chk("done_single", 64'(bus.done),      64'd0);
        chk("busy_idle",   64'(bus.busy),      64'd0);
        chk("ones_cnt",    64'(bus.ones_cnt),  64'(pk(mcnt[2], mcnt[1], mcnt[0])));
        beats   = hs;
        cnt_out = bus.ones_cnt;
    endtask

    initial begin
        int          beats;
        int          dones;
        logic [14:0] cnt;
        logic [3:0]  rlo;
        logic [3:0]  rhi;

        n_pass  = 0;
        n_total = 0;
        model_defaults();

        vec[0] = '{4'd0,  4'd15, 1'b0, 1'b0, 2'd0, 16'h0000, 16, pk(6, 7, 4)};
        vec[1] = '{4'd14, 4'd1,  1'b0, 1'b0, 2'd0, 16'h0000, 4,  pk(1, 2, 1)};
        vec[2] = '{4'd5,  4'd5,  1'b0, 1'b0, 2'd0, 16'h0000, 1,  pk(1, 0, 0)};
        vec[3] = '{4'd0,  4'd15, 1'b1, 1'b0, 2'd0, 16'h0000, 16, pk(6, 7, 4)};
        vec[4] = '{4'd0,  4'd15, 1'b0, 1'b1, 2'd3, 16'h0000, 16, pk(6, 7, 4)};
        vec[5] = '{4'd0,  4'd15, 1'b0, 1'b1, 2'd0, 16'hFFFF, 16, pk(6, 7, 16)};

        rst_n         = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_sel   = '0;
        bus.cfg_data  = '0;
        bus.start     = 1'b0;
        bus.range_lo  = '0;
        bus.range_hi  = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_busy",  64'(bus.busy),      64'd0);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_last",  64'(bus.out_last),  64'd0);
        chk("rst_done",  64'(bus.done),      64'd0);
        chk("rst_idx",   64'(bus.out_idx),   64'd0);
        chk("rst_f",     64'(bus.out_f),     64'd0);
        chk("rst_ones",  64'(bus.ones_cnt),  64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_sweep(vec[i].lo, vec[i].hi, vec[i].rnd, vec[i].cfg, vec[i].sel, vec[i].data,
                     1'b0, beats, cnt);
            chk($sformatf("vec%0d_beats", i), 64'(beats), 64'(vec[i].beats));
            chk($sformatf("vec%0d_cnt", i),   64'(cnt),   64'(vec[i].cnt));
        end

        // start and cfg write while busy must both be ignored
        do_sweep(4'd0, 4'd15, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b1, beats, cnt);
        chk("busy_ignore_beats", 64'(beats), 64'd16);
        chk("busy_ignore_cnt",   64'(cnt),   64'(pk(6, 7, 16)));

        // reset in the middle of a sweep
        @(negedge clk);
        bus.start     = 1'b1;
        bus.range_lo  = 4'd0;
        bus.range_hi  = 4'd15;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_busy",  64'(bus.busy),      64'd0);
        chk("midrst_done",  64'(bus.done),      64'd0);
        chk("midrst_ones",  64'(bus.ones_cnt),  64'd0);
        chk("midrst_f",     64'(bus.out_f),     64'd0);
        chk("midrst_idx",   64'(bus.out_idx),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("midrst_no_done", 64'(dones), 64'd0);
        bus.out_ready = 1'b0;
        model_defaults();
        do_sweep(4'd3, 4'd2, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, beats, cnt);
        chk("post_rst_beats", 64'(beats), 64'd16);
        chk("post_rst_cnt",   64'(cnt),   64'(pk(6, 7, 4)));

        for (int r = 0; r < 8; r++) begin
            rlo = 4'($urandom_range(0, 15));
            rhi = 4'($urandom_range(0, 15));
            do_sweep(rlo, rhi, 1'b1, ($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)),
                     16'($urandom), 1'b0, beats, cnt);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
